// File: rtl/riscv_data_mem_if.sv
// Data-side bus between the execute pipeline (master) and the data memory responder (slave).
// A transfer happens in any cycle with req && ack; load data returns later with rvalid.
interface riscv_data_mem_if;
   logic        req;
   logic        rnw;
   logic [31:0] addr;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (
      output req, rnw, addr, wmask, wdata,
      input  ack, rdata, rvalid
   );

   modport slave (
      input  req, rnw, addr, wmask, wdata,
      output ack, rdata, rvalid
   );
endinterface

// File: rtl/riscv_data_mem.sv
// Data memory responder: byte-masked stores, in-order loads through a fixed-latency pipeline,
// and an optional zeroing sweep of the word array after every reset.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_INIT  | post-reset; sweeping clr_idx over the array (or one edge if no sweep)
// ST_READY | acknowledging traffic; init_done high
module riscv_data_mem #(
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    rstn,
   riscv_data_mem_if.slave         data_bif,
   output logic                    init_done
);

   localparam int AW    = MEM_DEPTH_LOG2;
   localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t          state;
   logic [AW-1:0]   clr_idx;
   logic [31:0]     mem [DEPTH];

   logic [AW-1:0]   word_idx;
   logic            ready;
   logic            accept;
   logic            ld_accept;
   logic            st_accept;
   logic            clr_we;

   logic [31:0]             pipe_data [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_vld;

   // Upper address bits alias and the byte offset is the initiator's concern.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{data_bif.addr[31:MEM_DEPTH_LOG2+2], data_bif.addr[1:0]};

   assign word_idx  = data_bif.addr[MEM_DEPTH_LOG2+1:2];
   assign ready     = (state == ST_READY);
   assign accept    = data_bif.req && ready;
   assign ld_accept = accept && data_bif.rnw;
   assign st_accept = accept && !data_bif.rnw;
   assign clr_we    = (state == ST_INIT) && CLEAR_ON_RESET;

   assign data_bif.ack = ready;
   assign init_done    = ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_INIT;
         clr_idx <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (!CLEAR_ON_RESET) begin
                  state <= ST_READY;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
                  if (clr_idx == {AW{1'b1}}) state <= ST_READY;
               end
            end
            ST_READY: state <= ST_READY;
            default:  state <= ST_INIT;
         endcase
      end
   end

   // Array contents are deliberately not reset; the INIT sweep owns clearing.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (st_accept) begin
         for (int i = 0; i < 4; i++) begin
            if (data_bif.wmask[i]) mem[word_idx][8*i +: 8] <= data_bif.wdata[8*i +: 8];
         end
      end
   end

   // Data stages only advance behind a valid, so the last stage holds between pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
      end else begin
         pipe_vld[0] <= ld_accept;
         if (ld_accept) pipe_data[0] <= mem[word_idx];
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign data_bif.rdata  = pipe_data[READ_LATENCY-1];
   assign data_bif.rvalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_riscv_data_mem.sv
// Scoreboard bench for riscv_data_mem: a word-array reference model predicts load data and
// return cycle; a separate monitor pops and compares on every rvalid.
module tb_riscv_data_mem;

   localparam int MDL   = 4;
   localparam int LAT   = 3;
   localparam int WORDS = 1 << MDL;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic init_done;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] model_mem [WORDS];
   exp_t        exp_q [$];
   logic [31:0] last_exp = '0;

   riscv_data_mem_if bif ();

   riscv_data_mem #(
      .MEM_DEPTH_LOG2 (MDL),
      .READ_LATENCY   (LAT),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .data_bif  (bif),
      .init_done (init_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req_v);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
   endtask

   // Present one transfer at a negedge, wait for ack, then update the model for the coming edge.
   task automatic issue(input logic rnw, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wd);
      int n;
      int idx;
      exp_t e;
      @(negedge clk);
      bif.req = 1'b1; bif.rnw = rnw; bif.addr = addr; bif.wmask = mask; bif.wdata = wd;
      n = 0;
      while (bif.ack !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (bif.ack !== 1'b1) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got ack=%b after %0d cycles, required 1", bif.ack, n);
         return;
      end
      idx = (addr / 4) % WORDS;
      if (rnw) begin
         e.data = model_mem[idx];
         e.cyc  = cyc + LAT;
         exp_q.push_back(e);
      end else begin
         for (int i = 0; i < 4; i++)
            if (mask[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bif.req = 1'b0;
      end
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      rstn = 1'b0;
      bif.req = 1'b0;
      exp_q.delete();
      last_exp = '0;
      model_clear();
      #1;
      chk("reset_ack", {31'b0, bif.ack}, 32'd0);
      chk("reset_init_done", {31'b0, init_done}, 32'd0);
      chk("reset_rvalid", {31'b0, bif.rvalid}, 32'd0);
      chk("reset_rdata", bif.rdata, 32'd0);
      repeat (hold) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < WORDS; i++) begin
         #1;
         chk("sweep_ack_low", {31'b0, bif.ack}, 32'd0);
         chk("sweep_init_done_low", {31'b0, init_done}, 32'd0);
         @(negedge clk);
      end
      #1;
      chk("sweep_ack_high", {31'b0, bif.ack}, 32'd1);
      chk("sweep_init_done_high", {31'b0, init_done}, 32'd1);
   endtask

   // Monitor: samples just after each negedge, fully decoupled from stimulus.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (bif.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h at cycle %0d, required no response",
                        bif.rdata, cyc);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (bif.rdata !== e.data) begin
                  errors++;
                  $display("FAIL load_data: got %h, required %h", bif.rdata, e.data);
               end
               checks++;
               if (cyc != e.cyc) begin
                  errors++;
                  $display("FAIL load_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
               end
               last_exp = e.data;
            end
         end else begin
            checks++;
            if (bif.rdata !== last_exp) begin
               errors++;
               $display("FAIL rdata_hold: got %h, required %h", bif.rdata, last_exp);
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
               e = exp_q.pop_front();
               checks++; errors++;
               $display("FAIL missing_rvalid: got none by cycle %0d, required %h at cycle %0d",
                        cyc, e.data, e.cyc);
            end
         end
      end
   end

   initial begin
      int n;
      bif.req = 1'b0; bif.rnw = 1'b0; bif.addr = '0; bif.wmask = '0; bif.wdata = '0;
      model_clear();

      do_reset(3);

      issue(1'b1, 32'h0000_003C, 4'h0, 32'h0);
      idle(1);

      issue(1'b0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
      issue(1'b1, 32'h0000_0100, 4'h0, 32'h0);
      idle(1);

      issue(1'b0, 32'h0000_0008, 4'hF, 32'h1122_3344);
      issue(1'b0, 32'h0000_0008, 4'h4, 32'hAAAA_AAAA);
      issue(1'b1, 32'h0000_0008, 4'h0, 32'h0);
      issue(1'b0, 32'h0000_0008, 4'h0, 32'h5555_5555);
      issue(1'b1, 32'h0000_0008, 4'h0, 32'h0);
      idle(2);

      issue(1'b0, 32'h0000_0000, 4'hF, 32'd1);
      issue(1'b0, 32'h0000_0004, 4'hF, 32'd2);
      issue(1'b0, 32'h0000_0008, 4'hF, 32'd3);
      issue(1'b1, 32'h0000_0000, 4'h0, 32'h0);
      issue(1'b1, 32'h0000_0004, 4'h0, 32'h0);
      issue(1'b1, 32'h0000_0008, 4'h0, 32'h0);
      idle(2);

      issue(1'b0, 32'h0000_0040, 4'hF, 32'h5A5A_5A5A);
      issue(1'b1, 32'h0000_0000, 4'h0, 32'h0);
      idle(1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) idle(1);
         else issue(1'(($urandom_range(0, 1))), $urandom, 4'($urandom_range(0, 15)), $urandom);
      end
      idle(LAT + 2);

      issue(1'b0, 32'h0000_0020, 4'hF, 32'hCAFE_F00D);
      issue(1'b1, 32'h0000_0020, 4'h0, 32'h0);
      idle(1);
      do_reset(2);
      issue(1'b1, 32'h0000_0020, 4'h0, 32'h0);
      issue(1'b1, $urandom, 4'h0, 32'h0);
      idle(1);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending loads, required 0", exp_q.size());
      end
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
